// File: rtl/bf_mem_arbiter_if.sv
// Bus bundle between the CPU instruction/data ports, the program loader
// and the single-port byte RAM. The arbiter takes the slave view.
interface bf_mem_arbiter_if #(
  parameter int MEM_ADDR_W = 17,
  parameter int I_ADDR_W   = 16,
  parameter int D_ADDR_W   = 8
);
  logic                  i_req;
  logic [I_ADDR_W-1:0]   i_addr;
  logic                  i_ack;
  logic [7:0]            i_rdata;

  logic                  d_req;
  logic                  d_dir;
  logic [D_ADDR_W-1:0]   d_addr;
  logic [7:0]            d_wdata;
  logic                  d_ack;
  logic [7:0]            d_rdata;

  logic                  ld_req;
  logic                  ld_we;
  logic [MEM_ADDR_W-1:0] ld_addr;
  logic [7:0]            ld_wdata;
  logic                  ld_ack;
  logic [7:0]            ld_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [7:0]            mem_wdata;
  logic [7:0]            mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_dir, d_addr, d_wdata,
           ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, ld_ack, ld_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_dir, d_addr, d_wdata,
           ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, ld_ack, ld_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/bf_mem_arbiter.sv
// Three-way arbiter in front of one synchronous byte RAM. The loader always
// wins; instruction and data ports alternate round-robin. Each access takes
// three cycles: grant/issue, RAM sample, response.
module bf_mem_arbiter #(
  parameter int                    MEM_ADDR_W = 17,
  parameter int                    I_ADDR_W   = 16,
  parameter int                    D_ADDR_W   = 8,
  parameter logic [MEM_ADDR_W-1:0] D_BASE     = 17'h10000
) (
  input logic clk,
  input logic rst,
  bf_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {GNT_I, GNT_D, GNT_LD} gnt_t;

  state_t state, state_nxt;
  gnt_t   gnt, gnt_nxt;

  logic [2:0]            done;
  logic [2:0]            eligible;
  logic                  rr;
  logic                  gnt_we;
  logic                  grant_valid;
  logic                  sel_we;
  logic [MEM_ADDR_W-1:0] sel_addr;
  logic [7:0]            sel_wdata;
  logic [MEM_ADDR_W-1:0] i_addr_ext;
  logic [MEM_ADDR_W-1:0] d_addr_ext;

  // Map both CPU spaces into the unified RAM; the data region wraps at the top.
  assign i_addr_ext = {{(MEM_ADDR_W-I_ADDR_W){1'b0}}, bus.i_addr};
  assign d_addr_ext = D_BASE + {{(MEM_ADDR_W-D_ADDR_W){1'b0}}, bus.d_addr};

  // A port already served keeps its req high until it sees the ack; done masks it.
  assign eligible = {bus.ld_req & ~done[2], bus.d_req & ~done[1], bus.i_req & ~done[0]};

  // State and grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= GNT_I;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
    end
  end

  // Next state, grant choice and the selected request's address/data.
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    grant_valid = 1'b0;
    sel_we      = 1'b0;
    sel_addr    = '0;
    sel_wdata   = '0;
    case (state)
      IDLE: begin
        if (eligible[2]) begin
          gnt_nxt     = GNT_LD;
          grant_valid = 1'b1;
        end else if (eligible[0] && eligible[1]) begin
          gnt_nxt     = rr ? GNT_D : GNT_I;
          grant_valid = 1'b1;
        end else if (eligible[0]) begin
          gnt_nxt     = GNT_I;
          grant_valid = 1'b1;
        end else if (eligible[1]) begin
          gnt_nxt     = GNT_D;
          grant_valid = 1'b1;
        end
        if (grant_valid) begin
          state_nxt = ACCESS;
          case (gnt_nxt)
            GNT_I: begin
              sel_addr = i_addr_ext;
            end
            GNT_D: begin
              sel_addr  = d_addr_ext;
              sel_we    = bus.d_dir;
              sel_wdata = bus.d_wdata;
            end
            default: begin
              sel_addr  = bus.ld_addr;
              sel_we    = bus.ld_we;
              sel_wdata = bus.ld_wdata;
            end
          endcase
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM strobes, acks, read data capture, done flags and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.i_ack     <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.ld_ack    <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
      bus.ld_rdata  <= '0;
      done          <= '0;
      rr            <= 1'b0;
      gnt_we        <= 1'b0;
    end else begin
      bus.i_ack  <= 1'b0;
      bus.d_ack  <= 1'b0;
      bus.ld_ack <= 1'b0;
      if (!bus.i_req)  done[0] <= 1'b0;
      if (!bus.d_req)  done[1] <= 1'b0;
      if (!bus.ld_req) done[2] <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= sel_we;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            gnt_we        <= sel_we;
            if (gnt_nxt != GNT_LD) rr <= (gnt_nxt == GNT_I);
          end
        end
        ACCESS: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
        end
        RESP: begin
          case (gnt)
            GNT_I: begin
              bus.i_rdata <= bus.mem_rdata;
              bus.i_ack   <= 1'b1;
              done[0]     <= 1'b1;
            end
            GNT_D: begin
              if (!gnt_we) bus.d_rdata <= bus.mem_rdata;
              bus.d_ack <= 1'b1;
              done[1]   <= 1'b1;
            end
            default: begin
              if (!gnt_we) bus.ld_rdata <= bus.mem_rdata;
              bus.ld_ack <= 1'b1;
              done[2]    <= 1'b1;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_mem_arbiter.sv
// Directed bench for bf_mem_arbiter: a behavioural RAM behind the default
// instance, plus a second instance with a high D_BASE to exercise address wrap.
module tb_bf_mem_arbiter;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  bf_mem_arbiter_if #(.MEM_ADDR_W(17), .I_ADDR_W(16), .D_ADDR_W(8)) bus ();
  bf_mem_arbiter_if #(.MEM_ADDR_W(17), .I_ADDR_W(16), .D_ADDR_W(8)) bus2 ();

  bf_mem_arbiter #(.MEM_ADDR_W(17), .I_ADDR_W(16), .D_ADDR_W(8), .D_BASE(17'h10000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  bf_mem_arbiter #(.MEM_ADDR_W(17), .I_ADDR_W(16), .D_ADDR_W(8), .D_BASE(17'h1FFF0)) dut_wrap (
    .clk(clk),
    .rst(rst),
    .bus(bus2.slave)
  );

  logic [7:0] ram [0:131071];

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM: read data appears the cycle after the enable edge.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) $display("[TB] FAIL reset_mem_strobes: en=%b we=%b expected 0 0", bus.mem_en, bus.mem_we);
    else passed++;
    total++;
    if ({bus.i_ack, bus.d_ack, bus.ld_ack} !== 3'b000) $display("[TB] FAIL reset_acks: got %b expected 000", {bus.i_ack, bus.d_ack, bus.ld_ack});
    else passed++;
    total++;
    if (bus.mem_addr !== 17'h0 || bus.mem_wdata !== 8'h0) $display("[TB] FAIL reset_mem_bus: addr=%h wdata=%h expected 0 0", bus.mem_addr, bus.mem_wdata);
    else passed++;
    total++;
    if ({bus.i_rdata, bus.d_rdata, bus.ld_rdata} !== 24'h0) $display("[TB] FAIL reset_rdata: got %h expected 000000", {bus.i_rdata, bus.d_rdata, bus.ld_rdata});
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_i_fetch();
    int extra_acks;
    bus.i_addr = 16'h0003;
    bus.i_req  = 1'b1;
    tick();
    total++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 17'h00003)
      $display("[TB] FAIL i_issue: en=%b we=%b addr=%h expected 1 0 00003", bus.mem_en, bus.mem_we, bus.mem_addr);
    else passed++;
    tick();
    total++;
    if (bus.mem_en !== 1'b0 || bus.i_ack !== 1'b0) $display("[TB] FAIL i_access: en=%b ack=%b expected 0 0", bus.mem_en, bus.i_ack);
    else passed++;
    tick();
    total++;
    if (bus.i_ack !== 1'b1 || bus.i_rdata !== 8'h2B) $display("[TB] FAIL i_resp: ack=%b rdata=%h expected 1 2b", bus.i_ack, bus.i_rdata);
    else passed++;
    extra_acks = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.i_ack === 1'b1 || bus.mem_en === 1'b1) extra_acks++;
    end
    total++;
    if (extra_acks !== 0) $display("[TB] FAIL i_single_ack: extra activity cycles=%0d expected 0", extra_acks);
    else passed++;
    bus.i_req = 1'b0;
    tick();
    total++;
    if (bus.i_rdata !== 8'h2B) $display("[TB] FAIL i_rdata_hold: got %h expected 2b", bus.i_rdata);
    else passed++;
  endtask

  task automatic test_d_write_read();
    bus.d_dir   = 1'b1;
    bus.d_addr  = 8'hFF;
    bus.d_wdata = 8'h5A;
    bus.d_req   = 1'b1;
    tick();
    total++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 17'h100FF || bus.mem_wdata !== 8'h5A)
      $display("[TB] FAIL d_write_issue: en=%b we=%b addr=%h wdata=%h expected 1 1 100ff 5a", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    else passed++;
    bus.d_wdata = 8'h00;
    bus.d_dir   = 1'b0;
    tick();
    tick();
    total++;
    if (bus.d_ack !== 1'b1 || bus.d_rdata !== 8'h00) $display("[TB] FAIL d_write_ack: ack=%b rdata=%h expected 1 00", bus.d_ack, bus.d_rdata);
    else passed++;
    bus.d_req = 1'b0;
    tick();
    bus.d_dir = 1'b0;
    bus.d_req = 1'b1;
    tick();
    total++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 17'h100FF)
      $display("[TB] FAIL d_read_issue: en=%b we=%b addr=%h expected 1 0 100ff", bus.mem_en, bus.mem_we, bus.mem_addr);
    else passed++;
    tick();
    tick();
    total++;
    if (bus.d_ack !== 1'b1 || bus.d_rdata !== 8'h5A) $display("[TB] FAIL d_read_resp: ack=%b rdata=%h expected 1 5a", bus.d_ack, bus.d_rdata);
    else passed++;
    bus.d_req = 1'b0;
    tick();
  endtask

  task automatic test_d_wrap();
    bus2.d_dir  = 1'b0;
    bus2.d_addr = 8'h20;
    bus2.d_req  = 1'b1;
    tick();
    total++;
    if (bus2.mem_en !== 1'b1 || bus2.mem_addr !== 17'h00010) $display("[TB] FAIL d_wrap_addr: en=%b addr=%h expected 1 00010", bus2.mem_en, bus2.mem_addr);
    else passed++;
    tick();
    tick();
    total++;
    if (bus2.d_ack !== 1'b1) $display("[TB] FAIL d_wrap_ack: got %b expected 1", bus2.d_ack);
    else passed++;
    bus2.d_req = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    bus.i_addr = 16'h0003;
    bus.d_addr = 8'hFF;
    bus.d_dir  = 1'b0;
    for (int round = 0; round < 2; round++) begin
      bus.i_req = 1'b1;
      bus.d_req = 1'b1;
      tick();
      total++;
      if (bus.mem_addr !== 17'h00003) $display("[TB] FAIL rr_first_i round %0d: addr=%h expected 00003", round, bus.mem_addr);
      else passed++;
      tick();
      tick();
      total++;
      if (bus.i_ack !== 1'b1 || bus.d_ack !== 1'b0) $display("[TB] FAIL rr_i_ack round %0d: i=%b d=%b expected 1 0", round, bus.i_ack, bus.d_ack);
      else passed++;
      if (round == 1) bus.i_req = 1'b0;
      tick();
      total++;
      if (bus.mem_addr !== 17'h100FF || bus.mem_en !== 1'b1) $display("[TB] FAIL rr_then_d round %0d: en=%b addr=%h expected 1 100ff", round, bus.mem_en, bus.mem_addr);
      else passed++;
      tick();
      tick();
      total++;
      if (bus.d_ack !== 1'b1 || bus.i_ack !== 1'b0 || bus.d_rdata !== 8'h5A)
        $display("[TB] FAIL rr_d_ack round %0d: d=%b i=%b rdata=%h expected 1 0 5a", round, bus.d_ack, bus.i_ack, bus.d_rdata);
      else passed++;
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_priority();
    bus.ld_we    = 1'b1;
    bus.ld_addr  = 17'h00000;
    bus.ld_wdata = 8'h3E;
    bus.i_addr   = 16'h0000;
    bus.d_addr   = 8'hFF;
    bus.d_dir    = 1'b0;
    bus.ld_req   = 1'b1;
    bus.i_req    = 1'b1;
    bus.d_req    = 1'b1;
    tick();
    total++;
    if (bus.mem_addr !== 17'h00000 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 8'h3E)
      $display("[TB] FAIL prio_ld_issue: addr=%h we=%b wdata=%h expected 00000 1 3e", bus.mem_addr, bus.mem_we, bus.mem_wdata);
    else passed++;
    tick();
    tick();
    total++;
    if (bus.ld_ack !== 1'b1 || bus.i_ack !== 1'b0 || bus.d_ack !== 1'b0)
      $display("[TB] FAIL prio_ld_ack: ld=%b i=%b d=%b expected 1 0 0", bus.ld_ack, bus.i_ack, bus.d_ack);
    else passed++;
    bus.ld_req = 1'b0;
    tick();
    total++;
    if (bus.mem_addr !== 17'h00000 || bus.mem_we !== 1'b0 || bus.mem_en !== 1'b1)
      $display("[TB] FAIL prio_i_issue: en=%b addr=%h we=%b expected 1 00000 0", bus.mem_en, bus.mem_addr, bus.mem_we);
    else passed++;
    tick();
    tick();
    total++;
    if (bus.i_ack !== 1'b1 || bus.i_rdata !== 8'h3E) $display("[TB] FAIL prio_i_resp: ack=%b rdata=%h expected 1 3e", bus.i_ack, bus.i_rdata);
    else passed++;
    bus.i_req = 1'b0;
    tick();
    total++;
    if (bus.mem_addr !== 17'h100FF || bus.mem_en !== 1'b1) $display("[TB] FAIL prio_d_issue: en=%b addr=%h expected 1 100ff", bus.mem_en, bus.mem_addr);
    else passed++;
    tick();
    tick();
    total++;
    if (bus.d_ack !== 1'b1 || bus.d_rdata !== 8'h5A) $display("[TB] FAIL prio_d_resp: ack=%b rdata=%h expected 1 5a", bus.d_ack, bus.d_rdata);
    else passed++;
    bus.d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    int  acks_seen;
    bit  got_ack;
    bus.i_addr = 16'h0003;
    bus.i_req  = 1'b1;
    tick();
    total++;
    if (bus.mem_en !== 1'b1) $display("[TB] FAIL abort_issue: en=%b expected 1", bus.mem_en);
    else passed++;
    rst = 1'b1;
    bus.i_req = 1'b0;
    tick();
    total++;
    if (bus.mem_en !== 1'b0 || bus.i_ack !== 1'b0 || bus.i_rdata !== 8'h00)
      $display("[TB] FAIL abort_reset: en=%b ack=%b rdata=%h expected 0 0 00", bus.mem_en, bus.i_ack, bus.i_rdata);
    else passed++;
    rst = 1'b0;
    acks_seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.i_ack === 1'b1) acks_seen++;
    end
    total++;
    if (acks_seen !== 0) $display("[TB] FAIL abort_no_ack: acks=%0d expected 0", acks_seen);
    else passed++;
    bus.i_req = 1'b1;
    got_ack = 1'b0;
    for (int k = 0; k < 10 && !got_ack; k++) begin
      tick();
      if (bus.i_ack === 1'b1) got_ack = 1'b1;
    end
    total++;
    if (!got_ack || bus.i_rdata !== 8'h2B) $display("[TB] FAIL abort_reissue: ack_seen=%b rdata=%h expected 1 2b", got_ack, bus.i_rdata);
    else passed++;
    bus.i_req = 1'b0;
    tick();
  endtask

  // Test sequence.
  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    bus.i_req    = 1'b0; bus.i_addr  = '0;
    bus.d_req    = 1'b0; bus.d_dir   = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.ld_req   = 1'b0; bus.ld_we   = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
    bus.mem_rdata = '0;
    bus2.i_req   = 1'b0; bus2.i_addr = '0;
    bus2.d_req   = 1'b0; bus2.d_dir  = 1'b0; bus2.d_addr = '0; bus2.d_wdata = '0;
    bus2.ld_req  = 1'b0; bus2.ld_we  = 1'b0; bus2.ld_addr = '0; bus2.ld_wdata = '0;
    bus2.mem_rdata = '0;
    for (int a = 0; a < 131072; a++) ram[a] = 8'h00;
    ram[3] = 8'h2B;

    test_reset();
    test_i_fetch();
    test_d_write_read();
    test_d_wrap();
    test_round_robin();
    test_priority();
    test_reset_abort();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
